// File: rtl/pc_ras_if.sv
// Control/status bundle between the fetch controller and the PC/return-address-stack block.
// The master drives the next-PC controls; the slave (pc_ras) returns the PC and stack status.
interface pc_ras_if #(
    parameter int ADDR_W = 32
);
    logic              pcEN;
    logic              jump;
    logic [25:0]       imm26;
    logic              jr;
    logic [ADDR_W-1:0] jraddr;
    logic              ret;
    logic              link;
    logic              branch;
    logic [ADDR_W-1:0] immext;
    logic [ADDR_W-1:0] imemaddr;
    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_mispredict;
    logic              ras_ovf;
    logic              ras_unf;

    modport master (
        output pcEN, jump, imm26, jr, jraddr, ret, link, branch, immext,
        input  imemaddr, npc, ras_top, ras_empty, ras_full, ras_mispredict, ras_ovf, ras_unf
    );

    modport slave (
        input  pcEN, jump, imm26, jr, jraddr, ret, link, branch, immext,
        output imemaddr, npc, ras_top, ras_empty, ras_full, ras_mispredict, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_ras.sv
// Program counter with next-PC selection and a circular return-address stack.
// Calls push the link address; JR $31 pops it and uses it as the predicted return target.
module pc_ras #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] PC_INIT   = '0,
    parameter int                RAS_DEPTH = 4
) (
    input logic     CLK,
    input logic     nRST,
    pc_ras_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [RAS_DEPTH];

    logic              wr_en;
    logic [PW-1:0]     wr_idx;
    logic [ADDR_W-1:0] npc, br_tgt, jmp_tgt, top;
    logic              empty, full, push, pop;

    assign npc    = pc_q + ADDR_W'(4);
    assign br_tgt = npc + (bus.immext << 2);

    generate
        if (ADDR_W > 28) begin : g_jt_wide
            assign jmp_tgt = {npc[ADDR_W-1:28], bus.imm26, 2'b00};
        end else begin : g_jt_narrow
            assign jmp_tgt = {bus.imm26, 2'b00};
        end
    endgenerate

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_C);
    assign top   = empty ? '0 : stack_q[ptr_q];
    assign push  = bus.pcEN & bus.link;
    assign pop   = bus.pcEN & bus.jr & bus.ret;

    always_comb begin
        pc_d   = pc_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;

        if (bus.pcEN) begin
            if (bus.jump)                      pc_d = jmp_tgt;
            else if (bus.jr & bus.ret & !empty) pc_d = top;
            else if (bus.jr)                   pc_d = bus.jraddr;
            else if (bus.branch)               pc_d = br_tgt;
            else                               pc_d = npc;
        end

        // Push+pop on a non-empty stack rewrites the top in place; on an empty one it is a plain push.
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
        end else if (push) begin
            ptr_d  = ptr_q + PW'(1);
            wr_en  = 1'b1;
            wr_idx = ptr_q + PW'(1);
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + CW'(1);
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d = ptr_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q  <= PC_INIT;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entries are only visible through the count, so the storage needs no reset.
    always_ff @(posedge CLK) begin
        if (wr_en) stack_q[wr_idx] <= npc;
    end

    assign bus.imemaddr       = pc_q;
    assign bus.npc            = npc;
    assign bus.ras_top        = top;
    assign bus.ras_empty      = empty;
    assign bus.ras_full       = full;
    assign bus.ras_ovf        = ovf_q;
    assign bus.ras_unf        = unf_q;
    assign bus.ras_mispredict = bus.ret & bus.jr & !empty & (top != bus.jraddr);
endmodule

// File: doc/pc_ras.md
PC_RAS -- requirements
Module: pc_ras

Interface
REQ-001 SHALL have parameter PC_INIT, default 0: value loaded into the PC on reset.
REQ-002 SHALL have parameter ADDR_W, default 32: width of the PC and all address ports; legal values are 28 or greater.
REQ-003 SHALL have parameter RAS_DEPTH, default 4: number of return-address-stack entries; legal values are powers of two, 2 or greater.
REQ-004 CLK  in  1  clock; all state updates on the rising edge.
REQ-005 nRST  in  1  reset, asynchronous, active-low.
REQ-006 pcEN  in  1  PC/RAS update enable; when low, all state holds.
REQ-007 jump  in  1  J/JAL absolute jump.
REQ-008 imm26  in  26  jump target field.
REQ-009 jr  in  1  register jump.
REQ-010 jraddr  in  ADDR_W  register-file jump target.
REQ-011 ret  in  1  qualifies jr as a return (JR $31); valid only with jr.
REQ-012 link  in  1  call (JAL/JALR); pushes the return address.
REQ-013 branch  in  1  branch taken.
REQ-014 immext  in  ADDR_W  sign-extended branch offset, in words.
REQ-015 imemaddr  out  ADDR_W  current PC.
REQ-016 npc  out  ADDR_W  imemaddr+4, also the link value.
REQ-017 ras_top  out  ADDR_W  top entry; 0 when empty.
REQ-018 ras_empty  out  1  stack holds no entries.
REQ-019 ras_full  out  1  stack holds RAS_DEPTH entries.
REQ-020 ras_mispredict  out  1  combinational; ret & jr & !ras_empty & (ras_top != jraddr).
REQ-021 ras_ovf  out  1  sticky flag: a push occurred while full.
REQ-022 ras_unf  out  1  sticky flag: a pop occurred while empty.

Function
REQ-023 All arithmetic SHALL be modulo 2^ADDR_W: npc = pc+4; branch target = npc + (immext<<2); jump target = {npc[ADDR_W-1:28], imm26, 2'b00}.
REQ-024 Next-PC priority when pcEN=1 SHALL be, highest first:
  - jump -> jump target
  - jr&ret&!ras_empty -> ras_top
  - jr -> jraddr
  - branch -> branch target
  - otherwise -> npc
REQ-025 When pcEN=0, the PC, stack contents, count and sticky flags SHALL hold.
REQ-026 A push (link&pcEN) SHALL write npc to the top slot; the count increments, saturating at RAS_DEPTH.
REQ-027 A push while full SHALL overwrite the oldest entry, keep the count at RAS_DEPTH and set ras_ovf.
REQ-028 A pop (jr&ret&pcEN) SHALL remove the top entry; the count decrements.
REQ-029 A pop while empty SHALL leave the count at 0, set ras_unf, and select jraddr as the target.
REQ-030 A simultaneous push and pop SHALL replace the top entry with npc and leave the count unchanged; if the stack was empty, the result is a normal push and ras_unf is not set.
REQ-031 The stack SHALL be a circular buffer with a log2(RAS_DEPTH)-bit top pointer that wraps at both ends.
REQ-032 All outputs except ras_mispredict SHALL be registered state or pure functions of registered state.
REQ-033 The PC update latency SHALL be one cycle: imemaddr reflects the selected target on the edge after pcEN=1.

Reset
REQ-034 While nRST=0, SHALL force:
  - imemaddr=PC_INIT, npc=PC_INIT+4
  - count=0, pointer=0
  - ras_empty=1, ras_full=0, ras_top=0
  - ras_ovf=0, ras_unf=0
REQ-035 Reset asserted mid-operation SHALL take effect immediately, and the first edge after release with pcEN=1 SHALL fetch from PC_INIT+4 or the selected target.

Verification
REQ-036 Reset release, PC_INIT=0, pcEN=1, no controls, 3 cycles -> imemaddr 0,4,8,12.
REQ-037 pc=0x100, branch=1, immext=0xFFFFFFFF -> imemaddr=0x100.
REQ-038 pc=0x100, jump=1 and branch=1, imm26=0x40 -> imemaddr=0x100 (jump wins over branch).
REQ-039 Call/return sequence:
  - pc=0x200, jump&link -> ras_top=0x204, ras_empty=0
  - later jr&ret with jraddr=0x204 -> imemaddr=0x204, ras_mispredict=0, ras_empty=1
  - the same pop with jraddr=0x300 -> ras_mispredict=1 and target 0x204
REQ-040 RAS_DEPTH=4, 5 pushes from pc=0x10,0x20,0x30,0x40,0x50 -> ras_full=1, ras_ovf=1; then 4 pops return 0x54,0x44,0x34,0x24, then ras_empty=1.
REQ-041 Empty stack, jr&ret with jraddr=0x80 -> imemaddr=0x80, ras_unf=1; then hold pcEN=0 for 2 cycles -> all state unchanged.
